fir_xifu_wb: RTL and testbench
==============================

Name: fir_xifu_wb

Overview:
- Writeback stage of the FIR XIFU pipeline, directly downstream of the EX stage.
- Consumes the EX/WB register contents: instruction, id, rs1, rd and 32-bit result (dot-product value or post-incremented address).
- For loads, waits for the core LSU memory result, then writes the loaded word into the XIFU register file.
- Returns results and retire information to the core over the X-interface result channel with a valid/ready handshake, and back-pressures EX via ready_o.

Parameters:
- ID_WIDTH, 4, width of X-interface instruction id.
- NUM_XREGS, 8, number of XIFU registers; XW = $clog2(NUM_XREGS).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous flush to IDLE.
- valid_i  in  1  EX/WB holds a valid instruction.
- instr_i  in  2  opcode (INSTR_XFIRLW, INSTR_XFIRSW, INSTR_XFIRDOTP from fir_xifu_pkg).
- id_i  in  ID_WIDTH  instruction id.
- rs1_i  in  5  core GPR index of the base register.
- rd_i  in  5  destination register; low XW bits index the XIFU regfile.
- result_i  in  32  EX result.
- ready_o  out  1  WB accepts a new instruction this cycle.
- mem_result_valid_i  in  1  LSU load/store response valid.
- mem_result_id_i  in  ID_WIDTH  response id.
- mem_result_rdata_i  in  32  load data.
- mem_result_err_i  in  1  bus error.
- kill_i  in  1  core kill strobe.
- kill_id_i  in  ID_WIDTH  killed instruction id.
- result_valid_o  out  1  X-interface result valid.
- result_ready_i  in  1  X-interface result ready.
- result_id_o  out  ID_WIDTH  result id.
- result_data_o  out  32  data written to core GPR.
- result_rd_o  out  5  core GPR destination.
- result_we_o  out  1  core GPR write enable.
- rf_we_o  out  1  XIFU regfile write strobe.
- rf_waddr_o  out  XW  XIFU regfile write address.
- rf_wdata_o  out  32  XIFU regfile write data.

Behaviour:
- States: IDLE, WAIT_MEM, WAIT_RES. Registered fields: instr_q, id_q, rs1_q, rd_q, res_q, ldata_q, err_q.
- Reset (async) and clear_i (sync, highest priority over all events):
  - state = IDLE; all registers and outputs = 0.
  - Exception: ready_o = 1 while in IDLE.
- Accept:
  - ready_o = (state == IDLE); combinational, not gated by valid_i.
  - The instruction is captured on the clock edge where valid_i && ready_o.
  - Next state: XFIRLW → WAIT_MEM; XFIRSW and XFIRDOTP → WAIT_RES.
  - Minimum latency: result_valid_o high 1 cycle after acceptance.
- WAIT_MEM:
  - Leaves on mem_result_valid_i && mem_result_id_i == id_q: capture rdata into ldata_q and err into err_q, go to WAIT_RES.
  - Responses with a non-matching id are ignored.
- WAIT_RES:
  - result_valid_o = 1 unless the held instruction is being killed (see Kill).
  - result_id_o = id_q.
  - XFIRLW, XFIRSW: result_data_o = res_q, result_rd_o = rs1_q, result_we_o = 1 (post-increment write of the base register).
  - XFIRDOTP: result_we_o = 0, result_rd_o = 0, result_data_o = 0 (retire only).
  - If err_q = 1: result_we_o = 0.
  - Outputs are held stable until result_ready_i.
- Handshake cycle (result_valid_o && result_ready_i):
  - rf_we_o = 1 for exactly one cycle, for XFIRDOTP (wdata = res_q) and for XFIRLW with err_q = 0 (wdata = ldata_q).
  - rf_waddr_o = rd_q[XW-1:0].
  - Next state: IDLE.
  - rf_we_o = 0 in all other cycles. rf_waddr_o and rf_wdata_o are 0 when rf_we_o = 0.
- No instruction is accepted in the handshake cycle; back-to-back throughput is one instruction per 2 cycles at best.
- Kill:
  - Applies when kill_i && kill_id_i == id_q in WAIT_MEM or WAIT_RES.
  - result_valid_o is forced to 0 that cycle; no regfile write occurs; next state is IDLE.
  - Kill takes priority over a same-cycle mem response or result_ready_i.
  - Kill in IDLE, or with a non-matching id, has no effect.
- A mem response matching id_q while in WAIT_RES or IDLE is ignored.
- Stores: memory-side completion is not waited on. The XFIRSW response is ignored apart from the id-match rule.

Test Plan:
- XFIRDOTP id=2, rd=3, result_i=0x0000_0100, result_ready_i tied 1 → result_valid_o for 1 cycle at T+1 with we=0; rf_we_o=1, waddr=3, wdata=0x100 in the same cycle; ready_o back high at T+2.
- XFIRLW id=1, rs1=10, rd=5, result_i=0x1000_0004; mem response id=1, rdata=0xCAFEBABE after 3 cycles; result_ready_i low 2 cycles → result_data_o=0x10000004, rd=10, we=1, held stable; on the handshake rf write addr=5, data=0xCAFEBABE; ready_o low throughout.
- XFIRLW in WAIT_MEM, mem response with id=7 (mismatch) then id=1 → first ignored, transition only on id=1.
- XFIRLW with mem_result_err_i=1 → result we=0, no rf write, returns to IDLE.
- kill_i with kill_id=1 in WAIT_RES while result_ready_i=1 → result_valid_o=0, no rf write, IDLE next cycle; same with kill_id=2 → normal completion.
- clear_i or rst_ni low asserted in WAIT_MEM → IDLE, all outputs 0, ready_o=1; a later stale mem response is ignored.

Source files
------------

// File: rtl/fir_xifu_wb.sv
// rtl/fir_xifu_wb.sv - FIR XIFU writeback stage: load wait, X-interface result, regfile write
package fir_xifu_pkg;
    localparam logic [1:0] INSTR_XFIRLW   = 2'd0;
    localparam logic [1:0] INSTR_XFIRSW   = 2'd1;
    localparam logic [1:0] INSTR_XFIRDOTP = 2'd2;
endpackage

module fir_xifu_wb
    import fir_xifu_pkg::*;
#(
    parameter int ID_WIDTH  = 4,
    parameter int NUM_XREGS = 8,
    parameter int XW        = $clog2(NUM_XREGS)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,

    input  logic                valid_i,
    input  logic [1:0]          instr_i,
    input  logic [ID_WIDTH-1:0] id_i,
    input  logic [4:0]          rs1_i,
    input  logic [4:0]          rd_i,
    input  logic [31:0]         result_i,
    output logic                ready_o,

    input  logic                mem_result_valid_i,
    input  logic [ID_WIDTH-1:0] mem_result_id_i,
    input  logic [31:0]         mem_result_rdata_i,
    input  logic                mem_result_err_i,

    input  logic                kill_i,
    input  logic [ID_WIDTH-1:0] kill_id_i,

    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ID_WIDTH-1:0] result_id_o,
    output logic [31:0]         result_data_o,
    output logic [4:0]          result_rd_o,
    output logic                result_we_o,

    output logic                rf_we_o,
    output logic [XW-1:0]       rf_waddr_o,
    output logic [31:0]         rf_wdata_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WAIT_RES = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          instr_q, instr_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [4:0]          rs1_q, rs1_d;
    logic [4:0]          rd_q, rd_d;
    logic [31:0]         res_q, res_d;
    logic [31:0]         ldata_q, ldata_d;
    logic                err_q, err_d;

    logic kill_hit;
    logic mem_hit;
    logic res_valid;
    logic handshake;
    logic in_res;
    logic is_ldst;
    logic rf_we;

    always_comb begin
        kill_hit  = kill_i && (kill_id_i == id_q) && (state_q != IDLE);
        mem_hit   = mem_result_valid_i && (mem_result_id_i == id_q);
        in_res    = (state_q == WAIT_RES);
        res_valid = in_res && !kill_hit;
        handshake = res_valid && result_ready_i;
        is_ldst   = (instr_q == INSTR_XFIRLW) || (instr_q == INSTR_XFIRSW);
        // Loads write the fetched word, dot products write their own result.
        rf_we     = handshake && ((instr_q == INSTR_XFIRDOTP) ||
                                  ((instr_q == INSTR_XFIRLW) && !err_q));
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        id_d    = id_q;
        rs1_d   = rs1_q;
        rd_d    = rd_q;
        res_d   = res_q;
        ldata_d = ldata_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    instr_d = instr_i;
                    id_d    = id_i;
                    rs1_d   = rs1_i;
                    rd_d    = rd_i;
                    res_d   = result_i;
                    ldata_d = 32'd0;
                    err_d   = 1'b0;
                    state_d = (instr_i == INSTR_XFIRLW) ? WAIT_MEM : WAIT_RES;
                end
            end
            WAIT_MEM: begin
                if (kill_hit) begin
                    state_d = IDLE;
                end else if (mem_hit) begin
                    ldata_d = mem_result_rdata_i;
                    err_d   = mem_result_err_i;
                    state_d = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (kill_hit || handshake) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clear_i) begin
            state_d = IDLE;
            instr_d = 2'd0;
            id_d    = '0;
            rs1_d   = 5'd0;
            rd_d    = 5'd0;
            res_d   = 32'd0;
            ldata_d = 32'd0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            instr_q <= 2'd0;
            id_q    <= '0;
            rs1_q   <= 5'd0;
            rd_q    <= 5'd0;
            res_q   <= 32'd0;
            ldata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            id_q    <= id_d;
            rs1_q   <= rs1_d;
            rd_q    <= rd_d;
            res_q   <= res_d;
            ldata_q <= ldata_d;
            err_q   <= err_d;
        end
    end

    // Result fields are only driven while an instruction waits to retire.
    always_comb begin
        ready_o        = (state_q == IDLE);
        result_valid_o = res_valid;
        result_id_o    = in_res ? id_q : '0;
        result_data_o  = (in_res && is_ldst) ? res_q : 32'd0;
        result_rd_o    = (in_res && is_ldst) ? rs1_q : 5'd0;
        result_we_o    = in_res && is_ldst && !err_q;
        rf_we_o        = rf_we;
        rf_waddr_o     = rf_we ? rd_q[XW-1:0] : '0;
        rf_wdata_o     = rf_we ? ((instr_q == INSTR_XFIRDOTP) ? res_q : ldata_q) : 32'd0;
    end

endmodule

// File: tb/tb_fir_xifu_wb.sv
// tb/tb_fir_xifu_wb.sv - directed vector bench for fir_xifu_wb
module tb_fir_xifu_wb;
    import fir_xifu_pkg::*;

    localparam int ID_WIDTH = 4;
    localparam int XW       = 3;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic                clear_i;
    logic                valid_i;
    logic [1:0]          instr_i;
    logic [ID_WIDTH-1:0] id_i;
    logic [4:0]          rs1_i;
    logic [4:0]          rd_i;
    logic [31:0]         result_i;
    logic                ready_o;
    logic                mem_result_valid_i;
    logic [ID_WIDTH-1:0] mem_result_id_i;
    logic [31:0]         mem_result_rdata_i;
    logic                mem_result_err_i;
    logic                kill_i;
    logic [ID_WIDTH-1:0] kill_id_i;
    logic                result_valid_o;
    logic                result_ready_i;
    logic [ID_WIDTH-1:0] result_id_o;
    logic [31:0]         result_data_o;
    logic [4:0]          result_rd_o;
    logic                result_we_o;
    logic                rf_we_o;
    logic [XW-1:0]       rf_waddr_o;
    logic [31:0]         rf_wdata_o;

    fir_xifu_wb #(.ID_WIDTH(ID_WIDTH), .NUM_XREGS(8)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .clear_i            (clear_i),
        .valid_i            (valid_i),
        .instr_i            (instr_i),
        .id_i               (id_i),
        .rs1_i              (rs1_i),
        .rd_i               (rd_i),
        .result_i           (result_i),
        .ready_o            (ready_o),
        .mem_result_valid_i (mem_result_valid_i),
        .mem_result_id_i    (mem_result_id_i),
        .mem_result_rdata_i (mem_result_rdata_i),
        .mem_result_err_i   (mem_result_err_i),
        .kill_i             (kill_i),
        .kill_id_i          (kill_id_i),
        .result_valid_o     (result_valid_o),
        .result_ready_i     (result_ready_i),
        .result_id_o        (result_id_o),
        .result_data_o      (result_data_o),
        .result_rd_o        (result_rd_o),
        .result_we_o        (result_we_o),
        .rf_we_o            (rf_we_o),
        .rf_waddr_o         (rf_waddr_o),
        .rf_wdata_o         (rf_wdata_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0]  instr;
        logic [3:0]  id;
        logic [4:0]  rs1;
        logic [4:0]  rd;
        logic [31:0] res;
        logic [31:0] rdata;
        logic        err;
        int          mem_dly;
        int          rdy_dly;
        logic [31:0] exp_data;
        logic [4:0]  exp_rd;
        logic        exp_we;
        logic        exp_rfwe;
        logic [2:0]  exp_waddr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs [6];

    task automatic idle_inputs();
        clear_i            = 1'b0;
        valid_i            = 1'b0;
        instr_i            = 2'd0;
        id_i               = '0;
        rs1_i              = 5'd0;
        rd_i               = 5'd0;
        result_i           = 32'd0;
        mem_result_valid_i = 1'b0;
        mem_result_id_i    = '0;
        mem_result_rdata_i = 32'd0;
        mem_result_err_i   = 1'b0;
        kill_i             = 1'b0;
        kill_id_i          = '0;
        result_ready_i     = 1'b0;
    endtask

    task automatic accept(input logic [1:0] instr, input logic [3:0] id,
                          input logic [4:0] rs1, input logic [4:0] rd, input logic [31:0] res);
        @(negedge clk_i);
        valid_i  = 1'b1;
        instr_i  = instr;
        id_i     = id;
        rs1_i    = rs1;
        rd_i     = rd;
        result_i = res;
        #1 chk("accept_ready", ready_o, 1);
        @(negedge clk_i);
        valid_i = 1'b0;
    endtask

    task automatic mem_resp(input logic v, input logic [3:0] id, input logic [31:0] d, input logic e);
        mem_result_valid_i = v;
        mem_result_id_i    = id;
        mem_result_rdata_i = d;
        mem_result_err_i   = e;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ready"}, ready_o, 1);
        chk({tag, "_rvalid"}, result_valid_o, 0);
        chk({tag, "_rfwe"}, rf_we_o, 0);
        chk({tag, "_rid"}, result_id_o, 0);
        chk({tag, "_rdata"}, result_data_o, 0);
        chk({tag, "_rwe"}, result_we_o, 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string t;
        t = $sformatf("v%0d", idx);
        accept(v.instr, v.id, v.rs1, v.rd, v.res);
        if (v.instr == INSTR_XFIRLW) begin
            for (int k = 1; k <= v.mem_dly; k++) begin
                if (k == v.mem_dly) mem_resp(1'b1, v.id, v.rdata, v.err);
                #1;
                chk({t, "_memwait_valid"}, result_valid_o, 0);
                chk({t, "_memwait_ready"}, ready_o, 0);
                @(negedge clk_i);
                mem_resp(1'b0, 4'd0, 32'd0, 1'b0);
            end
        end
        for (int r = 0; r < v.rdy_dly; r++) begin
            result_ready_i = 1'b0;
            #1;
            chk({t, "_hold_valid"}, result_valid_o, 1);
            chk({t, "_hold_data"}, result_data_o, v.exp_data);
            chk({t, "_hold_rd"}, result_rd_o, v.exp_rd);
            chk({t, "_hold_we"}, result_we_o, v.exp_we);
            chk({t, "_hold_rfwe"}, rf_we_o, 0);
            chk({t, "_hold_ready"}, ready_o, 0);
            @(negedge clk_i);
        end
        result_ready_i = 1'b1;
        #1;
        chk({t, "_valid"}, result_valid_o, 1);
        chk({t, "_id"}, result_id_o, v.id);
        chk({t, "_data"}, result_data_o, v.exp_data);
        chk({t, "_rd"}, result_rd_o, v.exp_rd);
        chk({t, "_we"}, result_we_o, v.exp_we);
        chk({t, "_rfwe"}, rf_we_o, v.exp_rfwe);
        chk({t, "_waddr"}, rf_waddr_o, v.exp_waddr);
        chk({t, "_wdata"}, rf_wdata_o, v.exp_wdata);
        chk({t, "_ready_hs"}, ready_o, 0);
        @(negedge clk_i);
        result_ready_i = 1'b0;
        #1;
        check_idle({t, "_after"});
    endtask

    initial begin
        //           instr           id  rs1 rd  res           rdata         err mdly rdly exp_data      rd  we rfwe waddr wdata
        vecs[0] = '{INSTR_XFIRDOTP, 2,  0,  3,  32'h0000_0100, 32'h0,        0,  0,   0,   32'h0,        0,  0, 1,   3,    32'h0000_0100};
        vecs[1] = '{INSTR_XFIRLW,   1,  10, 5,  32'h1000_0004, 32'hCAFE_BABE, 0, 3,   2,   32'h1000_0004, 10, 1, 1,   5,    32'hCAFE_BABE};
        vecs[2] = '{INSTR_XFIRLW,   3,  4,  2,  32'h0000_0020, 32'h0000_DEAD, 1, 1,   0,   32'h0000_0020, 4,  0, 0,   0,    32'h0};
        vecs[3] = '{INSTR_XFIRSW,   5,  7,  1,  32'h3000_0008, 32'h0,        0,  0,   1,   32'h3000_0008, 7,  1, 0,   0,    32'h0};
        vecs[4] = '{INSTR_XFIRDOTP, 15, 0,  7,  32'hFFFF_FFFF, 32'h0,        0,  0,   1,   32'h0,        0,  0, 1,   7,    32'hFFFF_FFFF};
        vecs[5] = '{INSTR_XFIRDOTP, 9,  31, 12, 32'h8000_0001, 32'h0,        0,  0,   0,   32'h0,        0,  0, 1,   4,    32'h8000_0001};

        idle_inputs();
        rst_ni = 1'b0;
        #1;
        check_idle("reset");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Non-matching mem response is ignored, matching one completes the load.
        accept(INSTR_XFIRLW, 4'd1, 5'd10, 5'd5, 32'h1000_0004);
        mem_resp(1'b1, 4'd7, 32'h1111_1111, 1'b0);
        @(negedge clk_i);
        mem_resp(1'b0, 4'd0, 32'd0, 1'b0);
        #1;
        chk("mismatch_valid", result_valid_o, 0);
        chk("mismatch_ready", ready_o, 0);
        mem_resp(1'b1, 4'd1, 32'h2222_2222, 1'b0);
        @(negedge clk_i);
        mem_resp(1'b0, 4'd0, 32'd0, 1'b0);
        result_ready_i = 1'b1;
        #1;
        chk("match_valid", result_valid_o, 1);
        chk("match_rfwe", rf_we_o, 1);
        chk("match_wdata", rf_wdata_o, 32'h2222_2222);
        @(negedge clk_i);
        result_ready_i = 1'b0;

        // Matching kill in WAIT_RES beats result_ready_i.
        accept(INSTR_XFIRDOTP, 4'd1, 5'd0, 5'd2, 32'h55);
        kill_i = 1'b1; kill_id_i = 4'd1; result_ready_i = 1'b1;
        #1;
        chk("kill_valid", result_valid_o, 0);
        chk("kill_rfwe", rf_we_o, 0);
        @(negedge clk_i);
        kill_i = 1'b0; result_ready_i = 1'b0;
        #1;
        check_idle("kill_after");

        // Non-matching kill id has no effect.
        accept(INSTR_XFIRDOTP, 4'd1, 5'd0, 5'd2, 32'h66);
        kill_i = 1'b1; kill_id_i = 4'd2; result_ready_i = 1'b1;
        #1;
        chk("nokill_valid", result_valid_o, 1);
        chk("nokill_rfwe", rf_we_o, 1);
        chk("nokill_wdata", rf_wdata_o, 32'h66);
        @(negedge clk_i);
        kill_i = 1'b0; result_ready_i = 1'b0;
        #1;
        chk("nokill_ready", ready_o, 1);

        // Kill in WAIT_MEM wins over a same-cycle matching response.
        accept(INSTR_XFIRLW, 4'd4, 5'd3, 5'd1, 32'h40);
        kill_i = 1'b1; kill_id_i = 4'd4;
        mem_resp(1'b1, 4'd4, 32'h7777_7777, 1'b0);
        @(negedge clk_i);
        kill_i = 1'b0;
        mem_resp(1'b0, 4'd0, 32'd0, 1'b0);
        #1;
        check_idle("killmem_after");

        // Kill while IDLE is harmless.
        kill_i = 1'b1; kill_id_i = 4'd0;
        @(negedge clk_i);
        kill_i = 1'b0;
        #1;
        chk("killidle_ready", ready_o, 1);

        // clear_i in WAIT_MEM, then a stale response.
        accept(INSTR_XFIRLW, 4'd6, 5'd9, 5'd3, 32'h1234_5678);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        #1;
        check_idle("clear");
        mem_resp(1'b1, 4'd6, 32'h9999_9999, 1'b0);
        @(negedge clk_i);
        mem_resp(1'b0, 4'd0, 32'd0, 1'b0);
        #1;
        check_idle("clear_stale");

        // Async reset in WAIT_MEM, then a stale response.
        accept(INSTR_XFIRLW, 4'd6, 5'd9, 5'd3, 32'h1234_5678);
        rst_ni = 1'b0;
        #1;
        check_idle("rst_async");
        @(negedge clk_i);
        rst_ni = 1'b1;
        mem_resp(1'b1, 4'd6, 32'h9999_9999, 1'b0);
        @(negedge clk_i);
        mem_resp(1'b0, 4'd0, 32'd0, 1'b0);
        #1;
        check_idle("rst_stale");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
